// File: rtl/brightness_ctrl.sv
// brightness_ctrl: frame-synchronous coefficient controller with optional per-frame ramping.
// coe_o only changes on the cycle after a rising edge of vs_i (or on rst).
module brightness_ctrl #(
    parameter int COE_WIDTH    = 16,
    parameter int STEP_WIDTH   = 8,
    parameter int PERIOD_WIDTH = 8,
    parameter int COE_INIT     = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COE_WIDTH-1:0]    cfg_coe_i,
    input  logic [STEP_WIDTH-1:0]   cfg_step_i,
    input  logic [PERIOD_WIDTH-1:0] cfg_period_i,
    input  logic                    cfg_wr_i,
    input  logic                    vs_i,
    output logic [COE_WIDTH-1:0]    coe_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    frame_o
);
    typedef enum logic [1:0] {IDLE, PEND, RAMP} state_t;

    state_t                  state_q, state_d;
    logic [COE_WIDTH-1:0]    coe_q, coe_d, tgt_q, tgt_d;
    logic [STEP_WIDTH-1:0]   step_q, step_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d, cnt_q, cnt_d;
    logic                    vs_d_q, busy_q, busy_d, done_q, done_d, frame_q;
    logic                    sof, up;
    logic [COE_WIDTH:0]      diff, step_ext;
    logic [COE_WIDTH-1:0]    step_c, nxt_coe;

    assign sof = vs_i & ~vs_d_q;

    // One ramp step, evaluated one bit wider so neither direction can wrap
    always_comb begin
        up       = tgt_q > coe_q;
        diff     = up ? {1'b0, tgt_q} - {1'b0, coe_q} : {1'b0, coe_q} - {1'b0, tgt_q};
        step_ext = (COE_WIDTH+1)'(step_q);
        step_c   = COE_WIDTH'(step_q);
        nxt_coe  = (step_q == '0 || diff <= step_ext) ? tgt_q
                 : up ? coe_q + step_c : coe_q - step_c;
    end

    always_comb begin
        state_d  = state_q;
        coe_d    = coe_q;
        tgt_d    = tgt_q;
        step_d   = step_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (cfg_wr_i) begin
            tgt_d    = cfg_coe_i;
            step_d   = cfg_step_i;
            period_d = cfg_period_i;
            state_d  = PEND;
        end else if (sof && state_q != IDLE) begin
            if (state_q == PEND || cnt_q == '0) begin
                coe_d   = nxt_coe;
                cnt_d   = period_q;
                done_d  = nxt_coe == tgt_q;
                state_d = (nxt_coe == tgt_q) ? IDLE : RAMP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            coe_q    <= COE_WIDTH'(COE_INIT);
            tgt_q    <= COE_WIDTH'(COE_INIT);
            step_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            vs_d_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            coe_q    <= coe_d;
            tgt_q    <= tgt_d;
            step_q   <= step_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            vs_d_q   <= vs_i;
            busy_q   <= busy_d;
            done_q   <= done_d;
            frame_q  <= sof;
        end
    end

    assign coe_o   = coe_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign frame_o = frame_q;
endmodule
